// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit DIV/DIVU: radix-2 restoring divider with stall and sign fix-up.
// Latency 33 cycles issue-to-valid; stall is held from the issue cycle until the result cycle.
// No backpressure on the result; cancel aborts without a valid pulse, reset clears everything.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start_i,
    input  logic        div_signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        cancel_i,
    output logic        div_stall_o,
    output logic        div_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] rq_q;       // {partial remainder, quotient/dividend}
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        valid_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        ge;
    logic [31:0] diff;
    logic [63:0] rq_d;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] lo_d;
    logic [31:0] hi_d;

    // 33-bit trial: the bit shifted out of rq_q[63] makes the remainder exceed any divisor.
    always_comb begin
        ge   = rq_q[63] | (rq_q[62:31] >= dvs_q);
        diff = rq_q[62:31] - dvs_q;
        rq_d = ge ? {diff, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
    end

    always_comb begin
        a_mag = (div_signed_i && opa_i[31]) ? -opa_i : opa_i;
        b_mag = (div_signed_i && opb_i[31]) ? -opb_i : opb_i;
        lo_d  = (dvs_q == 32'd0) ? 32'hFFFF_FFFF : (qneg_q ? -rq_d[31:0] : rq_d[31:0]);
        hi_d  = rneg_q ? -rq_d[63:32] : rq_d[63:32];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rq_q    <= 64'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            valid_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            if (cancel_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (div_start_i) begin
                            rq_q    <= {32'd0, a_mag};
                            dvs_q   <= b_mag;
                            qneg_q  <= div_signed_i & (opa_i[31] ^ opb_i[31]);
                            rneg_q  <= div_signed_i & opa_i[31];
                            cnt_q   <= 5'd0;
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        rq_q <= rq_d;
                        if (cnt_q == 5'd31) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    // The issuing instruction is still present here, so start is ignored.
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign div_stall_o = ((state_q == IDLE) && div_start_i && !cancel_i) || (state_q == BUSY);
    assign div_valid_o = valid_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule
